// File: rtl/hpi_pkg.sv
// hpi_pkg
//   Shared types and constants for the CY7C67200 Host Port Interface
//   access controller.
//   - hpi_state_t : access sequencer phases
//   - HPI_*       : HPI register-select encodings carried on address/otg_addr
package hpi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      RECOVER
   } hpi_state_t;

   localparam logic [1:0] HPI_DATA    = 2'd0;
   localparam logic [1:0] HPI_MAILBOX = 2'd1;
   localparam logic [1:0] HPI_ADDR    = 2'd2;
   localparam logic [1:0] HPI_STATUS  = 2'd3;

endpackage

// File: rtl/hpi_access_ctrl.sv
// hpi_access_ctrl
//   Avalon-MM slave that runs one complete HPI bus cycle per host access
//   (setup / strobe / hold / recover) and stalls the master with
//   waitrequest until the cycle's hold phase ends.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   address[1:0]          HPI register select (DATA/MAILBOX/ADDRESS/STATUS)
//   chipselect/read/write Avalon request; read+write together is a write
//   writedata[15:0]       write data
//   readdata[15:0]        last completed read value
//   waitrequest           Avalon stall
//   otg_addr, otg_cs_n,
//   otg_rd_n, otg_wr_n    registered HPI control pins
//   otg_data_out/_oe      pad drive data and enable (tristate is at top level)
//   otg_data_in           pad input data
module hpi_access_ctrl
   import hpi_pkg::*;
#(
   parameter int unsigned SETUP_CYC   = 1,
   parameter int unsigned STROBE_CYC  = 4,
   parameter int unsigned HOLD_CYC    = 1,
   parameter int unsigned RECOVER_CYC = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        read,
   input  logic        write,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        waitrequest,
   output logic [1:0]  otg_addr,
   output logic        otg_cs_n,
   output logic        otg_rd_n,
   output logic        otg_wr_n,
   output logic [15:0] otg_data_out,
   output logic        otg_data_oe,
   input  logic [15:0] otg_data_in
);

   localparam int unsigned MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
   localparam int unsigned MAX_CD  = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
   localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

   localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_CYC - 1);

   hpi_state_t       state, next_state;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [1:0]       acc_addr, acc_addr_nx;
   logic             acc_wr, acc_wr_nx;
   logic [15:0]      acc_data, acc_data_nx;
   logic             ack, ack_nx;

   logic             req, active, capture;
   logic [1:0]       addr_nx;
   logic             cs_n_nx, rd_n_nx, wr_n_nx, oe_nx;
   logic [15:0]      dout_nx;

   assign req         = chipselect & (read | write);
   assign waitrequest = req & ~ack;

   // State register (also holds the latched access and all registered pins)
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         acc_addr     <= '0;
         acc_wr       <= 1'b0;
         acc_data     <= '0;
         ack          <= 1'b0;
         readdata     <= '0;
         otg_addr     <= '0;
         otg_cs_n     <= 1'b1;
         otg_rd_n     <= 1'b1;
         otg_wr_n     <= 1'b1;
         otg_data_out <= '0;
         otg_data_oe  <= 1'b0;
      end else begin
         state        <= next_state;
         cnt          <= cnt_next;
         acc_addr     <= acc_addr_nx;
         acc_wr       <= acc_wr_nx;
         acc_data     <= acc_data_nx;
         ack          <= ack_nx;
         otg_addr     <= addr_nx;
         otg_cs_n     <= cs_n_nx;
         otg_rd_n     <= rd_n_nx;
         otg_wr_n     <= wr_n_nx;
         otg_data_out <= dout_nx;
         otg_data_oe  <= oe_nx;
         if (capture) begin
            readdata <= otg_data_in;
         end
      end
   end

   // Next-state: one down-counter reloaded with (phase length - 1) per phase
   always_comb begin
      next_state  = state;
      cnt_next    = cnt;
      acc_addr_nx = acc_addr;
      acc_wr_nx   = acc_wr;
      acc_data_nx = acc_data;
      unique case (state)
         IDLE: begin
            if (req) begin
               next_state  = SETUP;
               cnt_next    = SETUP_LD;
               acc_addr_nx = address;
               acc_wr_nx   = write;
               acc_data_nx = writedata;
            end
         end
         SETUP: begin
            if (cnt == '0) begin
               next_state = STROBE;
               cnt_next   = STROBE_LD;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         STROBE: begin
            if (cnt == '0) begin
               next_state = HOLD;
               cnt_next   = HOLD_LD;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         HOLD: begin
            if (cnt == '0) begin
               next_state = RECOVER;
               cnt_next   = RECOVER_LD;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         RECOVER: begin
            if (cnt == '0) begin
               next_state = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         default: begin
            next_state = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Outputs: decoded from the upcoming state so every pin leaves a flop
   // aligned with the phase it belongs to.
   always_comb begin
      active  = (next_state == SETUP) || (next_state == STROBE) || (next_state == HOLD);
      cs_n_nx = ~active;
      addr_nx = active ? acc_addr_nx : '0;
      rd_n_nx = ~((next_state == STROBE) & ~acc_wr_nx);
      wr_n_nx = ~((next_state == STROBE) & acc_wr_nx);
      oe_nx   = active & acc_wr_nx;
      dout_nx = oe_nx ? acc_data_nx : '0;
      ack_nx  = (next_state == HOLD) && (cnt_next == '0);
      capture = (state == STROBE) && (cnt == '0) && ~acc_wr;
   end

endmodule
